// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Optional macro FETCH_PERF_EN (consumed by fetch_ctrl) adds stall/flush counters.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Byte distance between consecutive instructions.
  localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

  // Default first fetch address after reset.
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer that parks a fetched word while decode is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);

  logic            valid_q;
  logic [XLEN-1:0] data_q;

  // Capture on load; draining or clearing empties the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i || drain_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives imem requests and fills the IF/ID register.
// Optional macro FETCH_PERF_EN adds perf_stall_cnt / perf_flush_cnt ports.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        hazard_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_jump_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  target_q;
  logic         ifid_valid_q;
  logic [31:0]  ifid_instr_q;
  logic [31:0]  ifid_pc_q;

  logic [31:0]  pc_inc;
  logic [31:0]  redir_pc;
  logic         hb_load;
  logic         hb_drain;
  logic         hb_clear;
  logic         hb_valid;
  logic [31:0]  hb_data;

  assign pc_inc   = pc_q + INSN_BYTES;
  assign redir_pc = redirect_target & ~32'h0000_0003;

  // The buffer fills on an ack that decode cannot accept, and empties when
  // the stall releases or a redirect makes its word stale.
  assign hb_load  = (state_q == FETCH) && !redirect_valid && imem_ack && hazard_stall;
  assign hb_drain = (state_q == HOLD) && !redirect_valid && !hazard_stall;
  assign hb_clear = (state_q == HOLD) && redirect_valid;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hb_load),
    .drain_i (hb_drain),
    .clear_i (hb_clear),
    .data_i  (imem_rdata),
    .valid_o (hb_valid),
    .data_o  (hb_data)
  );

  // Fetch FSM, pc and IF/ID register; redirect outranks stall and ack everywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      target_q     <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
    end else begin
      // A flush kills IF/ID; otherwise an unstalled decode consumes it and
      // it stays live only if a new word is loaded below.
      if (redirect_valid || !hazard_stall) begin
        ifid_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            pc_q <= redir_pc;
          end
          state_q <= FETCH;
        end
        FETCH: begin
          if (redirect_valid) begin
            if (imem_ack) begin
              pc_q <= redir_pc;
            end else begin
              // Request still in flight: keep presenting it until it returns.
              target_q <= redir_pc;
              state_q  <= DRAIN;
            end
          end else if (imem_ack) begin
            if (hazard_stall) begin
              state_q <= HOLD;
            end else begin
              ifid_valid_q <= 1'b1;
              ifid_instr_q <= imem_rdata;
              ifid_pc_q    <= pc_inc;
              pc_q         <= pc_inc;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redir_pc;
            state_q <= FETCH;
          end else if (!hazard_stall) begin
            ifid_valid_q <= hb_valid;
            ifid_instr_q <= hb_data;
            ifid_pc_q    <= pc_inc;
            pc_q         <= pc_inc;
            state_q      <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc_q    <= redirect_valid ? redir_pc : target_q;
            state_q <= FETCH;
          end else if (redirect_valid) begin
            target_q <= redir_pc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req       = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr      = pc_q;
  assign ifid_valid     = ifid_valid_q;
  assign ifid_instr     = ifid_instr_q;
  assign ifid_pc        = ifid_pc_q;
  assign ifid_jump_addr = {ifid_pc_q[31:28], ifid_instr_q[25:0], 2'b00};

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating counts of stalled cycles and redirect cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (redirect_valid && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_jump_addr;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .hazard_stall    (hazard_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_jump_addr  (ifid_jump_addr)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic stall,
                       input logic redir, input logic [31:0] tgt);
    imem_ack        = ack;
    imem_rdata      = rdata;
    hazard_stall    = stall;
    redirect_valid  = redir;
    redirect_target = tgt;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", imem_req); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", ifid_valid); end
    n_cmp++; if ({ifid_instr, ifid_pc, ifid_jump_addr} !== 96'h0) begin n_err++;
      $display("FAIL reset_ifid got=%h/%h/%h want=0/0/0", ifid_instr, ifid_pc, ifid_jump_addr); end
    rst = 1'b0;
    $display("tx reset: req=%b valid=%b", imem_req, ifid_valid);
  endtask

  // Back-to-back acks from reset: addresses 0,4,8 and ifid_pc 4,8,12.
  task automatic test_stream();
    logic [31:0] exp_pc;
    drive(1'b1, 32'h2000_0001, 1'b0, 1'b0, 32'h0);  // ack in IDLE is ignored
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++;
      $display("FAIL stream_first_req got=%b/%h want=1/00000000", imem_req, imem_addr); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL stream_idle_ack got=%b want=0", ifid_valid); end
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(4 * (i + 1));
      n_cmp++; if (imem_addr !== exp_pc - 32'd4) begin n_err++;
        $display("FAIL stream_addr%0d got=%h want=%h", i, imem_addr, exp_pc - 32'd4); end
      imem_rdata = 32'h2000_0001 + 32'(i);
      tick();
      n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc || ifid_instr !== 32'h2000_0001 + 32'(i)) begin n_err++;
        $display("FAIL stream_ifid%0d got=%b/%h/%h want=1/%h/%h", i, ifid_valid, ifid_pc, ifid_instr,
                 exp_pc, 32'h2000_0001 + 32'(i)); end
      $display("tx stream: addr=%h ifid_pc=%h instr=%h", exp_pc - 32'd4, ifid_pc, ifid_instr);
    end
  endtask

  // Stall for 3 cycles with ack on the first; acks while holding are ignored.
  task automatic test_stall_hold();
    drive(1'b1, 32'h3000_0000, 1'b1, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req%0d got=%b want=0", i, imem_req); end
      n_cmp++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h2000_0003 || ifid_pc !== 32'd12) begin n_err++;
        $display("FAIL hold_frozen%0d got=%b/%h/%h want=1/20000003/0000000c", i, ifid_valid, ifid_instr, ifid_pc); end
      if (i < 2) begin
        drive(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 32'h0);
        tick();
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h3000_0000 || ifid_pc !== 32'd16) begin n_err++;
      $display("FAIL hold_release got=%b/%h/%h want=1/30000000/00000010", ifid_valid, ifid_instr, ifid_pc); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin n_err++;
      $display("FAIL hold_resume got=%b/%h want=1/00000010", imem_req, imem_addr); end
    $display("tx stall_hold: released instr=%h pc=%h", ifid_instr, ifid_pc);
  endtask

  // Redirect while awaiting ack, ack two cycles later, then a retarget inside DRAIN.
  task automatic test_redirect_drain();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    tick();
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL drain_flush got=%b want=0", ifid_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin n_err++;
      $display("FAIL drain_addr got=%b/%h want=1/00000010", imem_req, imem_addr); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (imem_addr !== 32'd16) begin n_err++; $display("FAIL drain_keep got=%h want=00000010", imem_addr); end
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (imem_addr !== 32'h100 || ifid_valid !== 1'b0) begin n_err++;
      $display("FAIL drain_done got=%h/%b want=00000100/0", imem_addr, ifid_valid); end
    imem_rdata = 32'h1111_1111;
    tick();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1111_1111 || ifid_pc !== 32'h104) begin n_err++;
      $display("FAIL drain_next got=%b/%h/%h want=1/11111111/00000104", ifid_valid, ifid_instr, ifid_pc); end
    $display("tx redirect_drain: target=%h", 32'h100);
    // Second redirect while draining replaces the stored target.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
    tick();
    n_cmp++; if (imem_addr !== 32'h104) begin n_err++; $display("FAIL retarget_keep got=%h want=00000104", imem_addr); end
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (imem_addr !== 32'h300 || imem_req !== 1'b1) begin n_err++;
      $display("FAIL retarget_addr got=%h/%b want=00000300/1", imem_addr, imem_req); end
    $display("tx drain_retarget: target=%h", imem_addr);
  endtask

  // Redirect and stall together (with ack): flush wins, no HOLD.
  task automatic test_redirect_stall();
    drive(1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'hBAD1_BAD1, 1'b1, 1'b1, 32'h0000_0500);
    tick();
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL redir_stall_valid got=%b want=0", ifid_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h500) begin n_err++;
      $display("FAIL redir_stall_pc got=%b/%h want=1/00000500", imem_req, imem_addr); end
    $display("tx redirect_stall: pc=%h", imem_addr);
  endtask

  // Redirect in HOLD discards the buffered word.
  task automatic test_hold_redirect();
    drive(1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0);
    tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hredir_hold got=%b want=0", imem_req); end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0600);
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h600 || ifid_valid !== 1'b0) begin n_err++;
      $display("FAIL hredir_pc got=%b/%h/%b want=1/00000600/0", imem_req, imem_addr, ifid_valid); end
    drive(1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (ifid_instr !== 32'h4444_4444 || ifid_pc !== 32'h604 || ifid_valid !== 1'b1) begin n_err++;
      $display("FAIL hredir_next got=%b/%h/%h want=1/44444444/00000604", ifid_valid, ifid_instr, ifid_pc); end
    $display("tx hold_redirect: instr=%h", ifid_instr);
  endtask

  // Jump address formation, then pc wrap with an unaligned target.
  task automatic test_jump_wrap();
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h4000_0004);
    tick();
    drive(1'b1, 32'h0800_0010, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (ifid_pc !== 32'h4000_0008 || ifid_jump_addr !== 32'h4000_0040) begin n_err++;
      $display("FAIL jump_addr got=%h/%h want=40000008/40000040", ifid_pc, ifid_jump_addr); end
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_align got=%h want=fffffffc", imem_addr); end
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (ifid_pc !== 32'h0 || imem_addr !== 32'h0 || ifid_valid !== 1'b1) begin n_err++;
      $display("FAIL wrap_pc got=%h/%h/%b want=00000000/00000000/1", ifid_pc, imem_addr, ifid_valid); end
    $display("tx jump_wrap: jump=%h", 32'h4000_0040);
  endtask

  // Reset with a request outstanding; the late ack lands in IDLE and is dropped.
  task automatic test_reset_mid();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0800);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin n_err++;
      $display("FAIL rstmid_state got=%b/%b want=0/0", imem_req, ifid_valid); end
    drive(1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (imem_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin n_err++;
      $display("FAIL rstmid_late_ack got=%h/%b/%h want=00000000/0/00000000", imem_addr, ifid_valid, ifid_instr); end
    $display("tx reset_mid: addr=%h", imem_addr);
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (perf_stall_cnt !== 16'h0 || perf_flush_cnt !== 16'h0) begin n_err++;
      $display("FAIL perf_reset got=%h/%h want=0000/0000", perf_stall_cnt, perf_flush_cnt); end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (perf_flush_cnt !== 16'd3) begin n_err++; $display("FAIL perf_flush got=%h want=0003", perf_flush_cnt); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 70000; i++) tick();
    n_cmp++; if (perf_stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL perf_sat got=%h want=ffff", perf_stall_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (perf_stall_cnt !== 16'h0 || perf_flush_cnt !== 16'h0) begin n_err++;
      $display("FAIL perf_clear got=%h/%h want=0000/0000", perf_stall_cnt, perf_flush_cnt); end
    $display("tx perf: stall counter saturated and cleared");
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_stall();
    test_hold_redirect();
    test_jump_wrap();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
